// File: rtl/fp16_acc_pkg.sv
// Shared types and constants for the binary16 group accumulator.
package fp16_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [4:0]  FP16_EXP_MAX  = 5'h1F;
    localparam logic [15:0] FP16_QNAN     = 16'h7E00;

endpackage

// File: rtl/fp16_accum_floatadd.sv
// Combinational binary16 adder, round-to-nearest-even, subnormal inputs and outputs.
module floatAdd
    import fp16_acc_pkg::*;
(
    input  logic [15:0] num1,
    input  logic [15:0] num2,
    output logic [15:0] result
);
    logic        swap, sa, sb, eff_sub, rnd_up;
    logic [15:0] a, b;
    logic [5:0]  ea, eb, diff, e_norm, e_out;
    logic [10:0] ma, mb;
    logic [13:0] a_ext, b_ext, b_al, norm;
    logic [14:0] sum;
    logic [4:0]  lz, sh;
    logic [11:0] rounded;

    assign swap = num2[14:0] > num1[14:0];
    assign a    = swap ? num2 : num1;
    assign b    = swap ? num1 : num2;
    assign sa   = a[15];
    assign sb   = b[15];
    assign ea   = (a[14:10] == 5'd0) ? 6'd1 : {1'b0, a[14:10]};
    assign eb   = (b[14:10] == 5'd0) ? 6'd1 : {1'b0, b[14:10]};
    assign ma   = {a[14:10] != 5'd0, a[9:0]};
    assign mb   = {b[14:10] != 5'd0, b[9:0]};
    assign diff = ea - eb;
    assign a_ext = {ma, 3'b000};
    assign b_ext = {mb, 3'b000};
    assign eff_sub = sa ^ sb;

    always_comb begin
        // Shifted-out bits collapse into the sticky position at bit 0.
        if (diff >= 6'd14) begin
            b_al = {13'd0, |b_ext};
        end else begin
            b_al = (b_ext >> diff) | {13'd0, |(b_ext & ((14'd1 << diff) - 14'd1))};
        end
        sum = eff_sub ? ({1'b0, a_ext} - {1'b0, b_al}) : ({1'b0, a_ext} + {1'b0, b_al});

        lz = 5'd14;
        for (int i = 0; i < 14; i++) begin
            if (sum[i]) lz = 5'(13 - i);
        end
        sh = ({1'b0, lz} > (ea - 6'd1)) ? 5'(ea - 6'd1) : lz;

        if (sum[14]) begin
            norm   = {sum[14:2], sum[1] | sum[0]};
            e_norm = ea + 6'd1;
        end else begin
            norm   = sum[13:0] << sh;
            e_norm = ea - {1'b0, sh};
        end

        rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded = {1'b0, norm[13:3]} + {11'd0, rnd_up};
        if (rounded[11]) begin
            e_out = e_norm + 6'd1;
        end else if (rounded[10]) begin
            e_out = e_norm;
        end else begin
            e_out = 6'd0;
        end

        if (a[14:10] == FP16_EXP_MAX || b[14:10] == FP16_EXP_MAX) begin
            if ((a[14:10] == FP16_EXP_MAX && a[9:0] != 10'd0) ||
                (b[14:10] == FP16_EXP_MAX && b[9:0] != 10'd0) ||
                (b[14:10] == FP16_EXP_MAX && eff_sub)) begin
                result = FP16_QNAN;
            end else begin
                result = {sa, FP16_EXP_MAX, 10'd0};
            end
        end else if (sum == 15'd0) begin
            result = {sa & sb, 15'd0};
        end else if (e_out >= 6'd31) begin
            result = {sa, FP16_EXP_MAX, 10'd0};
        end else begin
            result = {sa, e_out[4:0], rounded[11] ? 10'd0 : rounded[9:0]};
        end
    end

endmodule

// File: rtl/fp16_accum.sv
// Streaming binary16 group accumulator with count and sticky infinity flag.
// Optional macro FP16_ACC_FTZ_EN flushes subnormal inputs to signed zero.
module fp16_accum
    import fp16_acc_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [LEN_W-1:0] out_count,
    output logic             out_inf
);
    state_e             state_q, state_d;
    logic [15:0]        acc_q, acc_d, add_in, add_sum;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               inf_q, inf_d;
    logic               in_hs, out_hs;

`ifdef FP16_ACC_FTZ_EN
    assign add_in = (in_data[14:10] == 5'd0) ? {in_data[15], 15'd0} : in_data;
`else
    assign add_in = in_data;
`endif

    floatAdd u_add (
        .num1   (acc_q),
        .num2   (add_in),
        .result (add_sum)
    );

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= FP16_POS_ZERO;
            cnt_q   <= '0;
            inf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            inf_q   <= inf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        inf_d   = inf_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (in_hs) begin
                    state_d = in_last ? HOLD : ACCUM;
                    acc_d   = add_sum;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    inf_d   = inf_q | (add_sum[14:10] == FP16_EXP_MAX);
                end
            end
            HOLD: begin
                if (out_hs) begin
                    state_d = IDLE;
                    acc_d   = FP16_POS_ZERO;
                    cnt_d   = '0;
                    inf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == ACCUM);
        out_valid = (state_q == HOLD);
        out_data  = acc_q;
        out_count = cnt_q;
        out_inf   = inf_q;
    end

endmodule

// File: tb/tb_fp16_accum.sv
// Directed bench for fp16_accum; expected sums are hand-computed binary16 values.
module tb_fp16_accum;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_data = 16'h0000;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_data;
    logic [LEN_W-1:0] out_count;
    logic             out_inf;

    int checks = 0;
    int errors = 0;

    fp16_accum #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_inf   (out_inf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Offer one element; waits a bounded number of cycles for acceptance.
    task automatic push(input logic [15:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic expect_sum(input string tag, input logic [15:0] d,
                              input logic [LEN_W-1:0] c, input logic inf);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_count"}, 32'(out_count), 32'(c));
        check({tag, "_inf"},   32'(out_inf),   32'(inf));
    endtask

    initial begin
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_inf",   32'(out_inf),   32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        push(16'h3C00, 1'b0);
        check("mid_group_valid", 32'(out_valid), 32'd0);
        check("mid_group_ready", 32'(in_ready), 32'd1);
        push(16'h4000, 1'b1);
        expect_sum("add", 16'h4200, 2, 1'b0);
        consume();

        push(16'h3C00, 1'b0);
        push(16'hBC00, 1'b1);
        expect_sum("cancel", 16'h0000, 2, 1'b0);
        consume();

        push(16'h7BFF, 1'b0);
        push(16'h7BFF, 1'b1);
        expect_sum("ovf", 16'h7C00, 2, 1'b1);
        consume();

        push(16'h7BFF, 1'b0);
        push(16'h7BFF, 1'b0);
        push(16'h3C00, 1'b1);
        expect_sum("inf_sticky", 16'h7C00, 3, 1'b1);
        consume();

        push(16'h3C00, 1'b0);
        push(16'h3C00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data",  32'(out_data),  32'h4000);
            check("bp_count", 32'(out_count), 32'd2);
            @(posedge clk); #1;
        end
        consume();
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        check("bp_cleared_count", 32'(out_count), 32'd0);
        push(16'h3C00, 1'b1);
        expect_sum("after_bp", 16'h3C00, 1, 1'b0);
        consume();

        push(16'h0001, 1'b1);
`ifdef FP16_ACC_FTZ_EN
        expect_sum("subnormal", 16'h0000, 1, 1'b0);
`else
        expect_sum("subnormal", 16'h0001, 1, 1'b0);
`endif
        consume();

        push(16'h3C00, 1'b0);
        push(16'h3C00, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", 32'(out_count), 32'd0);
        check("async_rst_data",  32'(out_data),  32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        push(16'h4000, 1'b1);
        expect_sum("rst_mid", 16'h4000, 1, 1'b0);
        consume();

        for (int i = 0; i < 299; i++) push(16'h3C00, 1'b0);
        push(16'h0000, 1'b1);
        check("sat_count", 32'(out_count), 32'd255);
        check("sat_valid", 32'(out_valid), 32'd1);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
